// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding and constants for the SPI slave control FSM
package spi_pkg;
  typedef enum logic [2:0] {
    GET    = 3'd0,
    GOT    = 3'd1,
    READ1  = 3'd2,
    READ2  = 3'd3,
    READ3  = 3'd4,
    WRITE1 = 3'd5,
    WRITE2 = 3'd6,
    DONE   = 3'd7
  } state_t;
  localparam int WORD_W_DEF = 8;
  localparam logic RW_READ = 1'b1;
endpackage

// File: rtl/spi_bit_counter.sv
// spi_bit_counter: clearable, enabled up-counter that wraps to zero on its terminal count
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear, overrides en
//   en         : count enable
//   limit      : terminal count value
//   tc         : high while en is high and the count equals limit
module spi_bit_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic             tc
);
  logic [CNT_W-1:0] cnt;
  assign tc = en && (cnt == limit);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr || tc) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
endmodule

// File: rtl/spi_slave_fsm.sv
// spi_slave_fsm: SPI slave control FSM issuing single-cycle latch/load/write enables
//   clk, rst_n : clock, async active-low reset
//   sclk_pos   : one-clk pulse per conditioned SCLK rising edge
//   cs_n       : conditioned chip select, active-low
//   rw_bit     : header R/W bit from the shift register (1 = read)
//   addr_we    : address latch CE pulse
//   sr_we      : shift-register parallel-load pulse
//   dm_we      : data-memory write pulse
//   miso_buff  : MISO tri-state enable
//   state_dbg  : current state encoding
import spi_pkg::*;
module spi_slave_fsm #(
  parameter int WORD_W    = WORD_W_DEF,
  parameter int CNT_W     = 4,
  parameter int READ_WAIT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk_pos,
  input  logic       cs_n,
  input  logic       rw_bit,
  output logic       addr_we,
  output logic       sr_we,
  output logic       dm_we,
  output logic       miso_buff,
  output logic [2:0] state_dbg
);
  if ((2 ** CNT_W) <= WORD_W) begin : g_cnt_w_chk
    $error("CNT_W too narrow for WORD_W");
  end
  if (READ_WAIT < 1 || READ_WAIT > 15) begin : g_wait_chk
    $error("READ_WAIT out of range 1..15");
  end
  state_t state, nxt;
  logic bit_clr, bit_tc, wait_clr, wait_tc;
  // Counters are held at zero outside the states that use them, so each phase starts from 0.
  assign bit_clr  = cs_n || !(state inside {GET, READ3, WRITE1});
  assign wait_clr = cs_n || (state != READ1);
  spi_bit_counter #(.CNT_W(CNT_W)) u_bit_cnt (
    .clk(clk), .rst_n(rst_n), .clr(bit_clr), .en(sclk_pos),
    .limit(CNT_W'(WORD_W - 1)), .tc(bit_tc)
  );
  spi_bit_counter #(.CNT_W(4)) u_wait_cnt (
    .clk(clk), .rst_n(rst_n), .clr(wait_clr), .en(1'b1),
    .limit(4'(READ_WAIT - 1)), .tc(wait_tc)
  );
  always_comb begin
    nxt = state;
    if (cs_n) nxt = GET;
    else
      case (state)
        GET:    nxt = bit_tc ? GOT : GET;
        GOT:    nxt = (rw_bit == RW_READ) ? READ1 : WRITE1;
        READ1:  nxt = wait_tc ? READ2 : READ1;
        READ2:  nxt = READ3;
        READ3:  nxt = bit_tc ? DONE : READ3;
        WRITE1: nxt = bit_tc ? WRITE2 : WRITE1;
        WRITE2: nxt = DONE;
        DONE:   nxt = DONE;
      endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= GET;
    else state <= nxt;
  assign addr_we   = (state == GOT);
  assign sr_we     = (state == READ2);
  assign dm_we     = (state == WRITE2);
  assign miso_buff = (state == READ3);
  assign state_dbg = state;
endmodule
